// File: rtl/z80_bank_mmu_if.sv
// CPU-side and SRAM-side signal bundle for the Z80 banked memory controller.
// The master side is the CPU bus; the slave side is the controller itself.
interface z80_bank_mmu_if #(
  parameter int unsigned SRAM_AW = 18
);
  // CPU bus
  logic [15:0]        cpu_a;
  logic               cpu_n_mreq;
  logic               cpu_n_iorq;
  logic               cpu_n_rd;
  logic               cpu_n_wr;
  logic [7:0]         cpu_dout;
  logic [7:0]         mmu_dout;
  logic               mmu_n_sel;
  logic               cpu_n_wait;
  // SRAM port
  logic [SRAM_AW-1:0] ram_a;
  logic               ram_n_cs;
  logic               ram_n_oe;
  logic               ram_n_we;
  logic               ram_dout_en;
  // Status
  logic               rom_active;
  logic               mmu_en;

  modport master (
    output cpu_a, cpu_n_mreq, cpu_n_iorq, cpu_n_rd, cpu_n_wr, cpu_dout,
    input  mmu_dout, mmu_n_sel, cpu_n_wait,
    input  ram_a, ram_n_cs, ram_n_oe, ram_n_we, ram_dout_en,
    input  rom_active, mmu_en
  );

  modport slave (
    input  cpu_a, cpu_n_mreq, cpu_n_iorq, cpu_n_rd, cpu_n_wr, cpu_dout,
    output mmu_dout, mmu_n_sel, cpu_n_wait,
    output ram_a, ram_n_cs, ram_n_oe, ram_n_we, ram_dout_en,
    output rom_active, mmu_en
  );
endinterface

// File: rtl/z80_bank_mmu.sv
// Banked Z80 memory controller: window/page address translation into SRAM, boot-ROM
// overlay, I/O-programmed page/control registers and clk100 SRAM strobe sequencing.
module z80_bank_mmu #(
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned WIN_BITS      = 2,
  parameter logic [7:0]  MMU_IO_BASE   = 8'h78,
  parameter logic [7:0]  MMU_CTRL_PORT = 8'h7F,
  parameter logic [7:0]  ROM_DIS_PORT  = 8'h38,
  parameter int unsigned ROM_PAGE      = 0,
  parameter int unsigned STROBE_CYC    = 3
) (
  input logic           clk100,
  input logic           n_reset,
  z80_bank_mmu_if.slave bus
);

  localparam int unsigned PAGE_W  = SRAM_AW - 16 + WIN_BITS;
  localparam int unsigned NUM_WIN = 1 << WIN_BITS;
  localparam int unsigned OFF_W   = 16 - WIN_BITS;

  if (PAGE_W < 1 || PAGE_W > 8) begin : g_bad_page_w
    $error("z80_bank_mmu: PAGE_W must be in 1..8");
  end
  if (MMU_IO_BASE[WIN_BITS-1:0] != '0) begin : g_bad_io_base
    $error("z80_bank_mmu: MMU_IO_BASE must be aligned to the window count");
  end
  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
    $error("z80_bank_mmu: STROBE_CYC must be in 1..15");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers (reset to the inactive-high level)
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;
  logic       n_mreq_s, n_iorq_s, n_rd_s, n_wr_s;

  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {bus.cpu_n_mreq, bus.cpu_n_iorq, bus.cpu_n_rd, bus.cpu_n_wr};
      sync2_q <= sync1_q;
    end
  end

  assign {n_mreq_s, n_iorq_s, n_rd_s, n_wr_s} = sync2_q;

  logic mem_start, mem_is_wr, io_wr, io_rd;

  // rd and wr low together is not a valid memory cycle.
  assign mem_start = !n_mreq_s && (n_rd_s != n_wr_s);
  assign mem_is_wr = !n_wr_s;
  assign io_wr     = !n_iorq_s && !n_wr_s;
  assign io_rd     = !n_iorq_s && !n_rd_s;

  // ---------------------------------------------------------------------------
  // Page, control and overlay registers
  // ---------------------------------------------------------------------------
  logic [PAGE_W-1:0] page_q [NUM_WIN];
  logic [PAGE_W-1:0] page_d [NUM_WIN];
  logic              mmu_en_q, mmu_en_d;
  logic              rom_active_q, rom_active_d;

  logic              io_wr_q;
  logic [7:0]        io_addr_q;
  logic [PAGE_W-1:0] io_data_q;
  logic              io_commit;
  logic              wr_ctrl, wr_rom_dis, wr_page;

  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      io_wr_q   <= 1'b0;
      io_addr_q <= '0;
      io_data_q <= '0;
    end else begin
      io_wr_q <= io_wr;
      if (io_wr) begin
        io_addr_q <= bus.cpu_a[7:0];
        io_data_q <= bus.cpu_dout[PAGE_W-1:0];
      end
    end
  end

  // Registers are updated at the trailing edge of the I/O write, using the
  // address/data captured while the synchronised strobe was valid.
  assign io_commit  = io_wr_q && !io_wr;
  assign wr_ctrl    = (io_addr_q == MMU_CTRL_PORT);
  assign wr_rom_dis = (io_addr_q == ROM_DIS_PORT);
  assign wr_page    = (io_addr_q[7:WIN_BITS] == MMU_IO_BASE[7:WIN_BITS]) && !wr_ctrl;

  always_comb begin
    page_d       = page_q;
    mmu_en_d     = mmu_en_q;
    rom_active_d = rom_active_q;
    if (io_commit) begin
      if (wr_ctrl) begin
        mmu_en_d = io_data_q[0];
      end
      if (wr_rom_dis) begin
        rom_active_d = 1'b0;
      end
      if (wr_page) begin
        page_d[io_addr_q[WIN_BITS-1:0]] = io_data_q;
      end
    end
  end

  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        page_q[i] <= PAGE_W'(i);
      end
      mmu_en_q     <= 1'b0;
      rom_active_q <= 1'b1;
    end else begin
      page_q       <= page_d;
      mmu_en_q     <= mmu_en_d;
      rom_active_q <= rom_active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register readback
  // ---------------------------------------------------------------------------
  logic rd_ctrl, rd_page;

  assign rd_ctrl = io_rd && (bus.cpu_a[7:0] == MMU_CTRL_PORT);
  assign rd_page = io_rd && (bus.cpu_a[7:WIN_BITS] == MMU_IO_BASE[7:WIN_BITS]) && !rd_ctrl;

  always_comb begin
    bus.mmu_dout = '0;
    if (rd_ctrl) begin
      bus.mmu_dout = {7'b0, mmu_en_q};
    end else if (rd_page) begin
      bus.mmu_dout = 8'(page_q[bus.cpu_a[WIN_BITS-1:0]]);
    end
  end

  assign bus.mmu_n_sel = !(rd_ctrl || rd_page);

  // ---------------------------------------------------------------------------
  // Address translation
  // ---------------------------------------------------------------------------
  logic [WIN_BITS-1:0] win_idx;
  logic [PAGE_W-1:0]   xlat_page;
  logic [SRAM_AW-1:0]  xlat_addr;

  assign win_idx = bus.cpu_a[15 -: WIN_BITS];

  // Overlay applies to reads only; writes fall through to the RAM underneath.
  always_comb begin
    if (rom_active_q && (win_idx == '0) && !mem_is_wr) begin
      xlat_page = PAGE_W'(ROM_PAGE);
    end else if (mmu_en_q) begin
      xlat_page = page_q[win_idx];
    end else begin
      xlat_page = PAGE_W'(win_idx);
    end
  end

  assign xlat_addr = {xlat_page, bus.cpu_a[OFF_W-1:0]};

  // ---------------------------------------------------------------------------
  // Memory access FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-1:0] ram_a_q, ram_a_d;
  logic               is_wr_q, is_wr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_a_d = ram_a_q;
    is_wr_d = is_wr_q;
    unique case (state_q)
      StIdle: begin
        if (mem_start) begin
          state_d = StSetup;
          ram_a_d = xlat_addr;
          is_wr_d = mem_is_wr;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = 4'(STROBE_CYC - 1);
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = StDone;
      end
      StDone: begin
        if (n_mreq_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ram_a_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ram_a_q <= ram_a_d;
      is_wr_q <= is_wr_d;
    end
  end

  logic in_cycle;

  assign in_cycle        = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
  assign bus.ram_a       = ram_a_q;
  assign bus.ram_n_cs    = !in_cycle;
  assign bus.ram_n_oe    = !((state_q == StStrobe) && !is_wr_q);
  assign bus.ram_n_we    = !((state_q == StStrobe) && is_wr_q);
  assign bus.ram_dout_en = in_cycle && is_wr_q;
  assign bus.cpu_n_wait  = !((state_q == StSetup) || (state_q == StStrobe));
  assign bus.rom_active  = rom_active_q;
  assign bus.mmu_en      = mmu_en_q;

  logic unused_dout;
  assign unused_dout = ^bus.cpu_dout;

endmodule

// File: tb/tb_z80_bank_mmu.sv
// Self-checking bench for z80_bank_mmu: CPU bus tasks push expected SRAM accesses to a
// scoreboard that a strobe monitor pops and checks.
module tb_z80_bank_mmu;

  logic clk100;
  logic n_reset;

  z80_bank_mmu_if #(.SRAM_AW(18)) bus ();

  z80_bank_mmu dut (
    .clk100  (clk100),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [17:0] addr;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic strobe_now  = 1'b0;
  logic strobe_prev = 1'b0;
  int   slen        = 0;
  bit   abort       = 1'b0;

  // Scoreboard monitor: each strobe must match the oldest expected access.
  always @(negedge clk100) begin
    strobe_now = !bus.ram_n_oe || !bus.ram_n_we;
    if (strobe_now) begin
      check_eq("oe_den_overlap", 32'(!bus.ram_n_oe && bus.ram_dout_en), 0);
    end
    if (strobe_now && !strobe_prev) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check_eq("sb_addr", 32'(bus.ram_a), 32'(cur.addr));
        check_eq("sb_kind", 32'(!bus.ram_n_we), 32'(cur.wr));
        check_eq("sb_dout_en", 32'(bus.ram_dout_en), 32'(cur.wr));
      end
      slen = 1;
    end else if (strobe_now) begin
      slen++;
    end else if (strobe_prev) begin
      if (!abort) begin
        check_eq("strobe_len", slen, 3);
        check_eq("hold_cs", 32'(bus.ram_n_cs), 0);
        check_eq("hold_addr", 32'(bus.ram_a), 32'(cur.addr));
      end
      abort = 1'b0;
    end
    strobe_prev = strobe_now;
  end

  task automatic release_bus();
    bus.cpu_n_mreq = 1'b1;
    bus.cpu_n_iorq = 1'b1;
    bus.cpu_n_rd   = 1'b1;
    bus.cpu_n_wr   = 1'b1;
  endtask

  task automatic wait_release();
    for (int i = 0; i < 20; i++) begin
      if (bus.cpu_n_wait) break;
      @(negedge clk100);
    end
    check_eq("wait_release", 32'(bus.cpu_n_wait), 1);
  endtask

  task automatic mem_access(input logic [15:0] a, input logic wr, input logic [7:0] d,
                            input logic [17:0] exp_a);
    exp_q.push_back('{addr: exp_a, wr: wr});
    @(posedge clk100);
    #2;
    bus.cpu_a      = a;
    bus.cpu_dout   = d;
    bus.cpu_n_mreq = 1'b0;
    if (wr) bus.cpu_n_wr = 1'b0;
    else    bus.cpu_n_rd = 1'b0;
    repeat (3) @(negedge clk100);
    check_eq("lat_cs_pre", 32'(bus.ram_n_cs), 1);
    @(negedge clk100);
    check_eq("lat_cs", 32'(bus.ram_n_cs), 0);
    check_eq("wait_low", 32'(bus.cpu_n_wait), 0);
    check_eq("setup_addr", 32'(bus.ram_a), 32'(exp_a));
    check_eq("setup_dout_en", 32'(bus.ram_dout_en), 32'(wr));
    wait_release();
    release_bus();
    repeat (4) @(negedge clk100);
    check_eq("idle_cs", 32'(bus.ram_n_cs), 1);
    check_eq("idle_dout_en", 32'(bus.ram_dout_en), 0);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    @(posedge clk100);
    #2;
    bus.cpu_a      = {8'h00, port};
    bus.cpu_dout   = d;
    bus.cpu_n_iorq = 1'b0;
    bus.cpu_n_wr   = 1'b0;
    repeat (4) @(posedge clk100);
    #2;
    release_bus();
    repeat (4) @(posedge clk100);
  endtask

  task automatic io_read(input logic [7:0] port, input logic exp_sel_n, input logic [7:0] exp_d);
    @(posedge clk100);
    #2;
    bus.cpu_a      = {8'h00, port};
    bus.cpu_n_iorq = 1'b0;
    bus.cpu_n_rd   = 1'b0;
    repeat (3) @(negedge clk100);
    check_eq("in_sel", 32'(bus.mmu_n_sel), 32'(exp_sel_n));
    check_eq("in_data", 32'(bus.mmu_dout), 32'(exp_d));
    check_eq("in_wait", 32'(bus.cpu_n_wait), 1);
    release_bus();
    repeat (3) @(negedge clk100);
    check_eq("in_sel_idle", 32'(bus.mmu_n_sel), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  logic seen_low;
  logic got_strobe;

  initial begin
    n_reset      = 1'b0;
    bus.cpu_a    = 16'h0000;
    bus.cpu_dout = 8'h00;
    release_bus();
    #23;
    check_eq("rst_cs", 32'(bus.ram_n_cs), 1);
    check_eq("rst_oe", 32'(bus.ram_n_oe), 1);
    check_eq("rst_we", 32'(bus.ram_n_we), 1);
    check_eq("rst_den", 32'(bus.ram_dout_en), 0);
    check_eq("rst_wait", 32'(bus.cpu_n_wait), 1);
    check_eq("rst_rom", 32'(bus.rom_active), 1);
    check_eq("rst_en", 32'(bus.mmu_en), 0);
    check_eq("rst_ram_a", 32'(bus.ram_a), 0);
    check_eq("rst_sel", 32'(bus.mmu_n_sel), 1);
    check_eq("rst_dout", 32'(bus.mmu_dout), 0);
    @(negedge clk100);
    n_reset = 1'b1;
    repeat (2) @(negedge clk100);

    // Boot overlay active, identity map
    mem_access(16'h0123, 1'b0, 8'h00, 18'h00123);
    check_eq("rom_still_active", 32'(bus.rom_active), 1);
    mem_access(16'h4000, 1'b1, 8'h5A, 18'h04000);

    // Remap window 0 to page 5: reads still hit the ROM page, writes go to RAM
    io_write(8'h78, 8'h05);
    io_write(8'h7F, 8'h01);
    check_eq("mmu_en_set", 32'(bus.mmu_en), 1);
    mem_access(16'h0010, 1'b0, 8'h00, 18'h00010);
    mem_access(16'h0010, 1'b1, 8'h33, 18'h14010);

    io_write(8'h38, 8'h00);
    check_eq("rom_cleared", 32'(bus.rom_active), 0);
    mem_access(16'h0010, 1'b0, 8'h00, 18'h14010);

    // Window-index wrap and readback
    io_write(8'h7B, 8'h0F);
    mem_access(16'hFFFF, 1'b0, 8'h00, 18'h3FFFF);
    io_read(8'h7B, 1'b0, 8'h0F);
    io_read(8'h7F, 1'b0, 8'h01);
    io_read(8'h12, 1'b1, 8'h00);

    // Page rewrite between accesses
    mem_access(16'h8001, 1'b1, 8'hA5, 18'h08001);
    io_write(8'h7A, 8'h0A);
    mem_access(16'h8001, 1'b0, 8'h00, 18'h28001);

    // Translation off, overlay off: identity
    io_write(8'h7F, 8'h00);
    check_eq("mmu_en_clr", 32'(bus.mmu_en), 0);
    mem_access(16'hC005, 1'b0, 8'h00, 18'h0C005);
    mem_access(16'h0123, 1'b0, 8'h00, 18'h00123);

    // rd and wr together: no access
    @(posedge clk100);
    #2;
    bus.cpu_a      = 16'h2000;
    bus.cpu_n_mreq = 1'b0;
    bus.cpu_n_rd   = 1'b0;
    bus.cpu_n_wr   = 1'b0;
    seen_low   = 1'b0;
    got_strobe = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk100);
      seen_low   = seen_low | !bus.cpu_n_wait;
      got_strobe = got_strobe | !bus.ram_n_cs | !bus.ram_n_oe | !bus.ram_n_we;
    end
    check_eq("rdwr_wait", 32'(seen_low), 0);
    check_eq("rdwr_strobe", 32'(got_strobe), 0);
    release_bus();
    repeat (4) @(negedge clk100);

    // Reset asserted during STROBE of a write
    exp_q.push_back('{addr: 18'h04000, wr: 1'b1});
    @(posedge clk100);
    #2;
    bus.cpu_a      = 16'h4000;
    bus.cpu_dout   = 8'hC3;
    bus.cpu_n_mreq = 1'b0;
    bus.cpu_n_wr   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      if (!bus.ram_n_we) break;
    end
    check_eq("abort_we_seen", 32'(bus.ram_n_we), 0);
    abort = 1'b1;
    #2;
    n_reset = 1'b0;
    #1;
    check_eq("abort_we", 32'(bus.ram_n_we), 1);
    check_eq("abort_cs", 32'(bus.ram_n_cs), 1);
    check_eq("abort_wait", 32'(bus.cpu_n_wait), 1);
    check_eq("abort_den", 32'(bus.ram_dout_en), 0);
    release_bus();
    #10;
    n_reset = 1'b1;
    repeat (3) @(negedge clk100);
    check_eq("abort_rom", 32'(bus.rom_active), 1);
    check_eq("abort_en", 32'(bus.mmu_en), 0);
    io_write(8'h7F, 8'h01);
    io_read(8'h7B, 1'b0, 8'h03);
    io_read(8'h78, 1'b0, 8'h00);
    mem_access(16'h8001, 1'b0, 8'h00, 18'h08001);
    mem_access(16'h0010, 1'b1, 8'h11, 18'h00010);

    repeat (4) @(negedge clk100);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_bank_mmu.md
# z80_bank_mmu

Parametrised memory controller for the Z80 microcomputer that replaces the fixed 64K-into-SRAM mapping and the single ROM-disable latch. It sits between the CPU bus and the external SRAM port (in front of the bootstrap mux) and provides:

- banked address translation into the full SRAM;
- I/O-programmable page registers;
- a boot-ROM overlay that is cleared by an I/O write;
- SRAM strobe sequencing on `clk100`, with a CPU wait handshake.

## Interface

Parameters:
- `SRAM_AW`, 18: SRAM address width.
- `WIN_BITS`, 2: CPU space is split into 2^`WIN_BITS` windows, each of 2^(16-`WIN_BITS`) bytes.
- `PAGE_W`, derived as `SRAM_AW`-16+`WIN_BITS`: page register width. It must be between 1 and 8; elaboration fails otherwise.
- `MMU_IO_BASE`, 8'h78: page register i sits at I/O address `MMU_IO_BASE`+i. The base must be aligned to 2^`WIN_BITS`.
- `MMU_CTRL_PORT`, 8'h7F: control port. Bit 0 is `mmu_en`.
- `ROM_DIS_PORT`, 8'h38: any I/O write here clears `rom_active`.
- `ROM_PAGE`, 0: SRAM page that serves reads from window 0 while `rom_active` is high.
- `STROBE_CYC`, 3: number of `clk100` cycles that `ram_n_oe`/`ram_n_we` are held low. Range 1..15.

Ports:
- `clk100` in 1: system clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `cpu_a` in 16: CPU address.
- `cpu_n_mreq`, `cpu_n_iorq`, `cpu_n_rd`, `cpu_n_wr` in 1 each: CPU strobes. These are asynchronous to `clk100`.
- `cpu_dout` in 8: CPU write data.
- `mmu_dout` out 8: readback data for page/control registers.
- `mmu_n_sel` out 1: low while an I/O read targets a page or control register. Feeds the data-in mux.
- `cpu_n_wait` out 1: Z80 WAIT, active-low.
- `ram_a` out `SRAM_AW`: translated SRAM address.
- `ram_n_cs`, `ram_n_oe`, `ram_n_we` out 1 each: SRAM strobes.
- `ram_dout_en` out 1: high while the write data should drive the SRAM pins.
- `rom_active` out 1: boot overlay enabled.
- `mmu_en` out 1: translation enabled.

## Operation

Input synchronisation and decode:
- All `cpu_*` strobes pass through 2-FF synchronisers. Address and data are sampled only once the synchronised strobes are valid.
- A memory access is synchronised `mreq` low with exactly one of `rd`/`wr` low. Both `rd` and `wr` low together means no access.
- An I/O access is `iorq` low with `rd` or `wr` low.

Address translation (computed from `cpu_a`, latched in SETUP):
- Window index: idx = `cpu_a`[15:16-`WIN_BITS`].
- Page selection, in priority order:
  1. `rom_active`=1, idx=0 and the access is a read: page = `ROM_PAGE`.
  2. Otherwise, `mmu_en`=1: page = `page_reg`[idx].
  3. Otherwise: page = idx zero-extended, i.e. identity mapping of the low 64K.
- Writes to window 0 while `rom_active`=1 use the normal mapping (writes go to RAM underneath the ROM).
- `ram_a` = {page, `cpu_a`[15-`WIN_BITS`:0]}.

Register writes (taken on the rising edge of synchronised I/O `wr`, i.e. at the end of the write):
- `MMU_IO_BASE`+i: `page_reg`[i] <= `cpu_dout`[`PAGE_W`-1:0].
- `MMU_CTRL_PORT`: `mmu_en` <= `cpu_dout`[0].
- `ROM_DIS_PORT`: `rom_active` <= 0. Only reset sets it back to 1.

Register reads:
- An I/O read of a page register drives `mmu_n_sel`=0, combinational from the synchronised strobes.
- `mmu_dout` returns the register zero-extended to 8 bits. The control port returns {7'b0, `mmu_en`}.

Memory FSM:
- IDLE: wait for a memory-access start. On start, drive `cpu_n_wait`=0 and go to SETUP.
- SETUP (1 cycle): latch the translated address into `ram_a`, `ram_n_cs`=0. `ram_dout_en`=1 if the access is a write.
- STROBE (`STROBE_CYC` cycles): `ram_n_oe`=0 for reads, `ram_n_we`=0 for writes.
- HOLD (1 cycle): strobes high; `cs`, `ram_a` and `dout_en` held; `cpu_n_wait`=1.
- DONE: `ram_n_cs`=1, `ram_dout_en`=0. Stay until synchronised `mreq` is high, then go to IDLE.

The FSM always completes a started access. It never aborts mid-strobe.

## Timing

Reset values:
- Outputs: `ram_n_cs`/`ram_n_oe`/`ram_n_we`=1, `ram_dout_en`=0, `cpu_n_wait`=1, `rom_active`=1, `mmu_en`=0, `ram_a`=0, `mmu_n_sel`=1, `mmu_dout`=0.
- Internal: `page_reg`[i]=i.

Latency and handshake:
- From the CPU strobe edge to `ram_n_cs` falling: 3 `clk100` cycles (2 synchroniser cycles + IDLE→SETUP).
- `ram_n_oe`/`ram_n_we` are low for exactly `STROBE_CYC` cycles.
- Address and `cs` are stable 1 cycle before and 1 cycle after the strobe.
- `cpu_n_wait` is low from the IDLE→SETUP transition through the last STROBE cycle.
- `ram_dout_en` never overlaps a low `ram_n_oe`.

Boundary conditions:
- Reset asserted mid-access: all SRAM strobes go inactive immediately (asynchronous reset) and the FSM returns to IDLE.
- A page register rewritten between accesses takes effect on the next SETUP.
- An I/O cycle never starts the memory FSM.
- Window index wrap: address 16'hFFFF maps to {`page_reg`[2^`WIN_BITS`-1], all-ones offset}.

## Test plan

- Reset, then read 16'h0123: `ram_a`=18'h00123 (`ROM_PAGE`=0), `ram_n_oe` low for 3 cycles, `cpu_n_wait` released, `rom_active`=1.
- OUT 8'h38, then read 16'h0123: `rom_active`=0 and `ram_a`=18'h00123 via the identity map. Write 16'h4000 while `rom_active`=1: `ram_a`=18'h04000 and `ram_n_we` pulses.
- OUT 8'h7B←4'hF, OUT 8'h7F←1, then read 16'hFFFF: `ram_a`=18'h3FFFF. IN 8'h7B returns 8'h0F with `mmu_n_sel`=0.
- Memory write with `cpu_dout`=8'hA5: `ram_dout_en` high from SETUP to HOLD, `ram_n_we` low 3 cycles and never overlapping `ram_n_oe`; `ram_n_cs` is high after the FSM returns to IDLE.
- Pulse `n_reset` low during STROBE: `ram_n_we`, `ram_n_cs`, `cpu_n_wait`=1 immediately; `page_reg` and `rom_active` are restored to their reset values.
- `rd` and `wr` asserted together with `mreq`: no SRAM strobe and `cpu_n_wait` stays 1.
